// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared encodings for the instruction/data memory arbiter.
//               Holds the FSM state encoding, the owner encoding and the
//               default data-burst limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_owner_t;

  localparam int c_MAX_D_BURST_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Winner selection between the instruction and data requesters.
//               Data normally wins a collision; after MAX_D_BURST consecutive
//               data grants taken while an instruction request was waiting,
//               the instruction side wins once.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_inst_req     - instruction request
//               i_data_req     - data request
//               i_grant        - a grant is being taken this cycle
//               o_pick_data    - 1 = DATA wins, 0 = INST wins
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_BURST = c_MAX_D_BURST_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inst_req,
  input  logic i_data_req,
  input  logic i_grant,
  output logic o_pick_data
);

  localparam int SW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] c_STREAK_MAX = SW'(MAX_D_BURST);

  logic [SW-1:0] r_d_streak;
  logic          w_at_limit;
  logic          w_pick_data;

  assign w_at_limit  = (r_d_streak == c_STREAK_MAX);
  // Data wins unless the waiting instruction side has been passed over too often
  assign w_pick_data = i_data_req & ~(i_inst_req & w_at_limit);
  assign o_pick_data = w_pick_data;

  // The streak only counts data grants that actually made the fetch side wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_streak <= '0;
    end else if (i_grant) begin
      if (w_pick_data && i_inst_req) begin
        if (!w_at_limit) begin
          r_d_streak <= r_d_streak + 1'b1;
        end
      end else begin
        r_d_streak <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter (instruction fetch / data) in front of a
//               single-port synchronous memory with 1-cycle read latency.
//               Each access runs IDLE -> ISSUE -> RESP, giving a 2-cycle
//               latency from the sampling edge to ack and one access per
//               3 cycles.
// Ports       : clk, rst                    - clock, sync active-high reset
//               i_req, i_addr               - instruction fetch request
//               i_ack, i_rdata              - fetch completion / data
//               d_req, d_addr, d_wdata, d_wen - data request (d_wen=0 read)
//               d_ack, d_rdata              - data completion / load data
//               mem_en, mem_addr, mem_wdata, mem_wen, mem_rdata - memory port
//               i_grant_cnt, d_grant_cnt    - grant performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MAX_D_BURST = c_MAX_D_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wen,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_owner;
  arb_owner_t        w_win_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wen;
  logic [31:0]       r_i_grant_cnt;
  logic [31:0]       r_d_grant_cnt;

  logic              w_pick_data;
  logic              w_grant;
  logic              w_mem_en;
  logic [3:0]        w_mem_wen;
  logic              w_i_ack;
  logic              w_d_ack;
  logic [31:0]       w_i_rdata;
  logic [31:0]       w_d_rdata;

  mem_arb_pick #(
    .MAX_D_BURST (MAX_D_BURST)
  ) u_pick (
    .clk         (clk),
    .rst         (rst),
    .i_inst_req  (i_req),
    .i_data_req  (d_req),
    .i_grant     (w_grant),
    .o_pick_data (w_pick_data)
  );

  assign w_win_owner = w_pick_data ? DATA : INST;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_wen   = 4'h0;
    w_i_ack     = 1'b0;
    w_d_ack     = 1'b0;
    w_i_rdata   = 32'h0;
    w_d_rdata   = 32'h0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_mem_en    = 1'b1;
        w_mem_wen   = (r_owner == DATA) ? r_wen : 4'h0;
        w_state_nxt = RESP;
      end
      RESP: begin
        // Memory read data arrives in this cycle, one edge after ISSUE
        if (r_owner == INST) begin
          w_i_ack   = 1'b1;
          w_i_rdata = mem_rdata;
        end else begin
          w_d_ack = 1'b1;
          if (r_wen == 4'h0) begin
            w_d_rdata = mem_rdata;
          end
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latches and grant counters; requester inputs are ignored after
  // the grant edge, so the access is immune to mid-flight changes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner       <= DATA;
      r_addr        <= '0;
      r_wdata       <= 32'h0;
      r_wen         <= 4'h0;
      r_i_grant_cnt <= 32'h0;
      r_d_grant_cnt <= 32'h0;
    end else if (w_grant) begin
      r_owner <= w_win_owner;
      if (w_win_owner == DATA) begin
        r_addr        <= d_addr;
        r_wdata       <= d_wdata;
        r_wen         <= d_wen;
        r_d_grant_cnt <= r_d_grant_cnt + 32'h1;
      end else begin
        // Fetches never write; mem_wdata keeps the last store value
        r_addr        <= i_addr;
        r_wen         <= 4'h0;
        r_i_grant_cnt <= r_i_grant_cnt + 32'h1;
      end
    end
  end

  assign mem_en      = w_mem_en;
  assign mem_wen     = w_mem_wen;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign i_ack       = w_i_ack;
  assign i_rdata     = w_i_rdata;
  assign d_ack       = w_d_ack;
  assign d_rdata     = w_d_rdata;
  assign i_grant_cnt = r_i_grant_cnt;
  assign d_grant_cnt = r_d_grant_cnt;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002 SHALL have parameter MAX_D_BURST, default 4, the number of consecutive data grants allowed while an instruction request waits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_req  input  1  instruction-fetch request; i_addr  input  ADDR_W  fetch address.
REQ-006 SHALL have ports i_ack  output  1  fetch complete; i_rdata  output  32  fetched word.
REQ-007 SHALL have ports d_req  input  1  data request; d_addr  input  ADDR_W; d_wdata  input  32; d_wen  input  4  byte write enables, 0 = read.
REQ-008 SHALL have ports d_ack  output  1  data access complete; d_rdata  output  32  load data.
REQ-009 SHALL have ports mem_en  output  1; mem_addr  output  ADDR_W; mem_wdata  output  32; mem_wen  output  4; mem_rdata  input  32. These drive a single-port synchronous memory with 1-cycle read latency.
REQ-010 SHALL have ports i_grant_cnt  output  32 and d_grant_cnt  output  32  grant performance counters.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, RESP; the owner register (INST/DATA) SHALL be valid in ISSUE and RESP.
REQ-012 In IDLE, if either request is high at a clock edge, the FSM SHALL latch the winner, its address, wdata and wen, then enter ISSUE; otherwise it SHALL stay in IDLE.
REQ-013 Arbitration SHALL use this rule: d_req alone -> DATA; i_req alone -> INST; both -> DATA, unless d_streak == MAX_D_BURST, in which case INST.
REQ-014 d_streak SHALL increment on each DATA grant while i_req is high, SHALL clear on any INST grant, and SHALL clear on a DATA grant with i_req low. It SHALL saturate at MAX_D_BURST.
REQ-015 In ISSUE, the block SHALL assert mem_en=1 for exactly one cycle with the registered mem_addr. mem_wen SHALL equal the latched d_wen for DATA and 0 for INST. The FSM then SHALL go to RESP.
REQ-016 In RESP, the block SHALL pulse the owner's ack for exactly one cycle, then return to IDLE.
REQ-017 The acked read SHALL present i_rdata/d_rdata = mem_rdata. The other rdata, and d_rdata for a write, SHALL be 0.
REQ-018 Latency SHALL be 2 cycles from the sampling edge to ack. Throughput SHALL be one access per 3 cycles.
REQ-019 Requesters SHALL hold req, address and data stable until ack. The block SHALL ignore changes after latching.
REQ-020 A requester that keeps req high in the cycle of its own ack SHALL be treated as a new request in the following IDLE cycle.
REQ-021 Outside ISSUE, mem_en SHALL be 0 and mem_wen SHALL be 0. mem_addr and mem_wdata hold their last value.
REQ-022 i_grant_cnt and d_grant_cnt SHALL increment by 1 per grant in IDLE and SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-024 While rst=1 at a clock edge: state SHALL go to IDLE; owner = DATA; d_streak = 0.
REQ-025 While rst=1 at a clock edge: all outputs SHALL be 0, including both counters, mem_addr and mem_wdata.
REQ-026 Reset asserted during ISSUE or RESP SHALL abort the access: no ack, no further mem_en. The memory write already issued in ISSUE is not undone.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), the owner encoding (INST=1'b0, DATA=1'b1) and the default MAX_D_BURST.
REQ-028 Winner selection and d_streak SHALL live in one sub-module, mem_arb_pick. The FSM, latches and counters SHALL remain in mem_arbiter.

Verification
REQ-029 Single fetch: i_req=1, i_addr=0x100, memory word 0x00000013 -> mem_en one cycle later with mem_addr=0x100 and mem_wen=0; then i_ack=1 with i_rdata=0x00000013 two cycles after the sampling edge; i_grant_cnt=1.
REQ-030 Store: d_req=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_wen=4'b1111 -> one cycle with mem_en=1, mem_wen=4'b1111, mem_wdata=0xDEADBEEF; then d_ack=1 with d_rdata=0.
REQ-031 Collision: i_req and d_req rise together -> DATA is served first. INST is served in the next IDLE and acked 5 cycles after the first sampling edge.
REQ-032 Starvation guard: i_req held with d_req held continuously (MAX_D_BURST=4) -> grant order D,D,D,D,I,D…; d_grant_cnt=4 at the first i_ack.
REQ-033 Reset mid-access: rst=1 in the ISSUE cycle of a fetch -> no i_ack; all outputs are 0 on the next cycle; a new fetch after rst=0 completes normally.
REQ-034 Counter wrap: i_grant_cnt forced to 0xFFFFFFFF, then one fetch -> i_grant_cnt=0 and d_grant_cnt unchanged.
